password_check: RTL and testbench

- Keypad-style access controller for the home-automation system.
- Holds a stored numeric password (reset default 45675) and compares it against the entered code on each press of the enter button.
- Drives `unlock` on a correct entry and latches `alarm` after repeated wrong entries.
- Program mode (`rsbuttonState` high) replaces the stored password, but only after the current password is entered correctly.

---
 rtl/password_pkg.sv | 28 ++
 rtl/password_check_if.sv | 31 +++
 rtl/edge_detect_rise.sv | 23 ++
 rtl/password_check.sv | 82 ++++++++
 tb/tb_password_check.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/password_pkg.sv
// Shared constants and types for the keypad password controller.
// The fail counter width is derived from MAX_TRIES.
package password_pkg;

    localparam int unsigned PW_WIDTH   = 17;
    localparam int unsigned MAX_TRIES  = 3;
    localparam int unsigned FAIL_CNT_W = $clog2(MAX_TRIES + 1);

    typedef logic [PW_WIDTH-1:0]   pw_t;
    typedef logic [FAIL_CNT_W-1:0] fail_cnt_t;

    localparam pw_t       DEFAULT_PW   = 17'd45675;
    localparam fail_cnt_t FAIL_CNT_MAX = fail_cnt_t'(MAX_TRIES);

    // Action decoded for the current cycle; at most one per enter event.
    typedef enum logic [1:0] {
        ActNone,
        ActUnlock,
        ActStore,
        ActFail
    } action_e;

    // Saturating increment: the counter never wraps past MAX_TRIES.
    function automatic fail_cnt_t fail_cnt_inc(input fail_cnt_t cnt);
        return (cnt == FAIL_CNT_MAX) ? cnt : cnt + fail_cnt_t'(1);
    endfunction

endpackage

// File: rtl/password_check_if.sv
// Keypad-side signal bundle: entered codes, mode/enter buttons and the
// unlock/alarm indications returned by the controller.
interface password_check_if;
    import password_pkg::*;

    pw_t  in_password;
    pw_t  change_password;
    logic rsbuttonState;
    logic e_buttonState;
    logic unlock;
    logic alarm;

    modport master (
        output in_password,
        output change_password,
        output rsbuttonState,
        output e_buttonState,
        input  unlock,
        input  alarm
    );

    modport slave (
        input  in_password,
        input  change_password,
        input  rsbuttonState,
        input  e_buttonState,
        output unlock,
        output alarm
    );

endinterface

// File: rtl/edge_detect_rise.sv
// One-cycle pulse on a 0->1 transition of a level that is already
// synchronous to clk; holding the level high yields a single pulse.
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic i_level,
    output logic o_pulse
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    // Combinational so the consumer acts at the first edge sampling the level high.
    assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/password_check.sv
// Keypad access controller: compares the entered code with the stored password,
// drives unlock, counts wrong entries into a sticky alarm, and reprograms the code.
module password_check
    import password_pkg::*;
(
    input logic             clk,
    input logic             rst,
    password_check_if.slave pw_if
);

    logic      w_enter;
    logic      w_match;
    fail_cnt_t w_fail_next;
    action_e   w_action;

    pw_t       r_stored_pw;
    fail_cnt_t r_fail_cnt;
    logic      r_unlock;
    logic      r_alarm;

    edge_detect_rise u_enter_edge (
        .clk     (clk),
        .rst     (rst),
        .i_level (pw_if.e_buttonState),
        .o_pulse (w_enter)
    );

    assign w_match     = (pw_if.in_password == r_stored_pw);
    assign w_fail_next = fail_cnt_inc(r_fail_cnt);

    // Mode is taken as sampled on the enter edge; an active alarm swallows every press.
    always_comb begin
        w_action = ActNone;
        if (w_enter && !r_alarm) begin
            if (!w_match) begin
                w_action = ActFail;
            end else if (pw_if.rsbuttonState) begin
                w_action = ActStore;
            end else begin
                w_action = ActUnlock;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stored_pw <= DEFAULT_PW;
            r_fail_cnt  <= '0;
            r_unlock    <= 1'b0;
            r_alarm     <= 1'b0;
        end else begin
            unique case (w_action)
                ActNone: begin
                end
                ActUnlock: begin
                    r_unlock   <= 1'b1;
                    r_fail_cnt <= '0;
                end
                ActStore: begin
                    r_stored_pw <= pw_if.change_password;
                    r_fail_cnt  <= '0;
                    r_unlock    <= 1'b0;
                end
                ActFail: begin
                    r_unlock   <= 1'b0;
                    r_fail_cnt <= w_fail_next;
                    if (w_fail_next == FAIL_CNT_MAX) begin
                        r_alarm <= 1'b1;
                    end
                end
            endcase
            // Program mode keeps the door locked regardless of any enter outcome.
            if (pw_if.rsbuttonState) begin
                r_unlock <= 1'b0;
            end
        end
    end

    assign pw_if.unlock = r_unlock;
    assign pw_if.alarm  = r_alarm;

endmodule

// File: tb/tb_password_check.sv
// Directed table-driven bench for password_check plus hand-written sequences
// for latency, mode-forced lock, same-cycle reset and mode/enter collisions.
module tb_password_check;
    import password_pkg::*;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_pass;

    password_check_if tb_if ();

    password_check dut (
        .clk   (clk),
        .rst   (rst),
        .pw_if (tb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    do_rst;
        logic  mode;
        pw_t   inp;
        pw_t   chg;
        int    hold;
        logic  exp_unlock;
        logic  exp_alarm;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic do_reset();
        tb_if.e_buttonState = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic press(input logic mode, input pw_t inp, input pw_t chg, input int hold);
        tb_if.rsbuttonState   = mode;
        tb_if.in_password     = inp;
        tb_if.change_password = chg;
        tb_if.e_buttonState   = 1'b1;
        repeat (hold) tick();
        tb_if.e_buttonState = 1'b0;
        tick();
    endtask

    function automatic vec_t mk(input string name, input bit do_rst, input logic mode,
                                input pw_t inp, input pw_t chg, input int hold,
                                input logic eu, input logic ea);
        vec_t v;
        v.name = name; v.do_rst = do_rst; v.mode = mode; v.inp = inp; v.chg = chg;
        v.hold = hold; v.exp_unlock = eu; v.exp_alarm = ea;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        tb_if.in_password     = '0;
        tb_if.change_password = '0;
        tb_if.rsbuttonState   = 1'b0;
        tb_if.e_buttonState   = 1'b0;

        vecs.push_back(mk("reset",           1, 0, 17'd0,     17'd0,     0,  0, 0));
        vecs.push_back(mk("prog_ok",         0, 1, 17'd45675, 17'd78954, 1,  0, 0));
        vecs.push_back(mk("unlock_new",      0, 0, 17'd78954, 17'd0,     1,  1, 0));
        vecs.push_back(mk("wrong1",          0, 0, 17'd45,    17'd0,     1,  0, 0));
        vecs.push_back(mk("wrong2",          0, 0, 17'd45,    17'd0,     1,  0, 0));
        vecs.push_back(mk("wrong3_alarm",    0, 0, 17'd45,    17'd0,     1,  0, 1));
        vecs.push_back(mk("alarm_ignores",   0, 0, 17'd78954, 17'd0,     1,  0, 1));
        vecs.push_back(mk("reset2",          1, 0, 17'd0,     17'd0,     0,  0, 0));
        vecs.push_back(mk("prog_bad_cur",    0, 1, 17'd1,     17'd500,   1,  0, 0));
        vecs.push_back(mk("default_kept",    0, 0, 17'd45675, 17'd0,     1,  1, 0));
        vecs.push_back(mk("new_not_stored",  0, 0, 17'd500,   17'd0,     1,  0, 0));
        vecs.push_back(mk("hold10_once",     0, 0, 17'd500,   17'd0,     10, 0, 0));
        vecs.push_back(mk("clear_after_hold",0, 0, 17'd45675, 17'd0,     1,  1, 0));
        vecs.push_back(mk("w_a",             0, 0, 17'd1,     17'd0,     1,  0, 0));
        vecs.push_back(mk("w_b",             0, 0, 17'd1,     17'd0,     1,  0, 0));
        vecs.push_back(mk("ok_clears_cnt",   0, 0, 17'd45675, 17'd0,     1,  1, 0));
        vecs.push_back(mk("w_c",             0, 0, 17'd1,     17'd0,     1,  0, 0));
        vecs.push_back(mk("w_d_no_alarm",    0, 0, 17'd1,     17'd0,     1,  0, 0));
        vecs.push_back(mk("ok_again",        0, 0, 17'd45675, 17'd0,     1,  1, 0));

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) begin
                do_reset();
            end else begin
                press(vecs[i].mode, vecs[i].inp, vecs[i].chg, vecs[i].hold);
            end
            check({vecs[i].name, "_unlock"}, tb_if.unlock, vecs[i].exp_unlock);
            check({vecs[i].name, "_alarm"},  tb_if.alarm,  vecs[i].exp_alarm);
        end

        // Unlock holds while idle.
        repeat (3) tick();
        check("idle_hold_unlock", tb_if.unlock, 1'b1);

        // Raising program mode alone clears unlock at the next edge.
        tb_if.rsbuttonState = 1'b1;
        check("mode_pre_edge", tb_if.unlock, 1'b1);
        tick();
        check("mode_forces_lock", tb_if.unlock, 1'b0);
        tb_if.rsbuttonState = 1'b0;
        tick();

        // Result registered at the first edge that samples the button high.
        tb_if.in_password   = 17'd45675;
        tb_if.e_buttonState = 1'b1;
        check("lat_pre_edge", tb_if.unlock, 1'b0);
        tick();
        check("lat_first_edge", tb_if.unlock, 1'b1);
        tb_if.e_buttonState = 1'b0;
        tick();

        // Reprogramming with an identical code is harmless.
        press(1'b1, 17'd45675, 17'd45675, 1);
        check("same_pw_prog", tb_if.unlock, 1'b0);
        press(1'b0, 17'd45675, 17'd0, 1);
        check("same_pw_unlock", tb_if.unlock, 1'b1);

        // Reset coinciding with an enter event wins, restoring the default code.
        press(1'b1, 17'd45675, 17'd78954, 1);
        tb_if.rsbuttonState = 1'b0;
        tb_if.in_password   = 17'd78954;
        tb_if.e_buttonState = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tb_if.e_buttonState = 1'b0;
        tick();
        check("rst_enter_unlock", tb_if.unlock, 1'b0);
        check("rst_enter_alarm", tb_if.alarm, 1'b0);
        press(1'b0, 17'd78954, 17'd0, 1);
        check("rst_old_pw_gone", tb_if.unlock, 1'b0);
        press(1'b0, 17'd45675, 17'd0, 1);
        check("rst_default_back", tb_if.unlock, 1'b1);

        // Mode change in the same cycle as enter: program action taken.
        tb_if.rsbuttonState   = 1'b1;
        tb_if.in_password     = 17'd45675;
        tb_if.change_password = 17'd222;
        tb_if.e_buttonState   = 1'b1;
        tick();
        check("mode_enter_same", tb_if.unlock, 1'b0);
        tb_if.e_buttonState = 1'b0;
        tb_if.rsbuttonState = 1'b0;
        tick();
        press(1'b0, 17'd222, 17'd0, 1);
        check("mode_enter_stored", tb_if.unlock, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
